// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Writeback-side initiator for the integer register file. It merges the
// in-order pipeline result stream and the out-of-order long-latency (MUL/DIV)
// result stream onto the single register-file write port. Long-latency
// results are parked in a small FIFO and drained into idle writeback slots.
// If the FIFO head waits too long, the pipeline is stalled for one slot so
// the head can drain. A 32-bit pending-destination scoreboard gives decode
// a RAW/WAW hazard stall.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   pipe_valid_i/rd/data  in-order pipeline result
//   pipe_stall_o          pipeline must hold its result (registered)
//   lu_issue_i/_rd_i      long-latency op issued this cycle (sets busy bit)
//   lu_valid_i/rd/data    long-latency result
//   lu_ready_o            FIFO can accept a result (not full)
//   rs1/rs2/rd_addr_i     decode-stage operand addresses
//   dec_stall_o           decode hazard stall (combinational from busy_o)
//   busy_o                scoreboard, one bit per architectural register
//   rw_en_o/waddr_o/wdata_o  register-file write port (registered)
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int XLEN          = 32,
    parameter int LU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pipe_valid_i,
    input  logic [4:0]      pipe_rd_i,
    input  logic [XLEN-1:0] pipe_data_i,
    output logic            pipe_stall_o,
    input  logic            lu_issue_i,
    input  logic [4:0]      lu_issue_rd_i,
    input  logic            lu_valid_i,
    input  logic [4:0]      lu_rd_i,
    input  logic [XLEN-1:0] lu_data_i,
    output logic            lu_ready_o,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic [4:0]      rd_addr_i,
    output logic            dec_stall_o,
    output logic [31:0]     busy_o,
    output logic            rw_en_o,
    output logic [4:0]      waddr_o,
    output logic [XLEN-1:0] wdata_o
);

    localparam int PTR_W    = (LU_FIFO_DEPTH > 1) ? $clog2(LU_FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(LU_FIFO_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    // FIFO storage and bookkeeping
    logic [XLEN-1:0]     r_fifo_data [LU_FIFO_DEPTH];
    logic [4:0]          r_fifo_rd   [LU_FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_pipe_stall;
    logic [31:0]         r_busy;
    logic                r_rw_en;
    logic [4:0]          r_waddr;
    logic [XLEN-1:0]     r_wdata;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_pipe_take;
    logic [4:0]          w_head_rd;
    logic [XLEN-1:0]     w_head_data;
    logic                w_sel_valid;
    logic [4:0]          w_sel_rd;
    logic [XLEN-1:0]     w_sel_data;
    logic                w_wr_en;
    logic [31:0]         w_set_mask;
    logic [31:0]         w_clr_mask;
    logic                w_issue_conflict;

    // Full/empty come from the registered count only, so lu_ready_o has no
    // path from lu_valid_i and a fresh push is never visible as the head in
    // its own cycle (no bypass).
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(LU_FIFO_DEPTH));
    assign w_push      = lu_valid_i && !w_full;
    assign w_pipe_take = pipe_valid_i && !r_pipe_stall;
    assign w_pop       = !w_empty && !w_pipe_take;
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Slot selection: pipeline has priority unless it is being held back.
    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = '0;
        w_sel_data  = '0;
        if (w_pipe_take) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = pipe_rd_i;
            w_sel_data  = pipe_data_i;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = w_head_rd;
            w_sel_data  = w_head_data;
        end
    end

    // A result to x0 is consumed but never written.
    assign w_wr_en = w_sel_valid && (w_sel_rd != 5'd0);

    // Scoreboard masks; bit 0 is never set.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (lu_issue_i && (lu_issue_rd_i != 5'd0)) begin
            w_set_mask[lu_issue_rd_i] = 1'b1;
        end
        if (w_pop) begin
            w_clr_mask[w_head_rd] = 1'b1;
        end
    end

    // Re-issuing to a register still pending is illegal, unless its result
    // is being retired in this very cycle.
    assign w_issue_conflict = lu_issue_i && (lu_issue_rd_i != 5'd0) &&
                              r_busy[lu_issue_rd_i] &&
                              !(w_pop && (w_head_rd == lu_issue_rd_i));

    // FIFO payload. NOTE: the storage array is deliberately left out of reset;
    // only the pointers/count define validity, and dropping the reset keeps
    // the array as plain registers/RAM without a reset fan-out.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= lu_data_i;
            r_fifo_rd[r_wr_ptr]   <= lu_rd_i;
        end
    end

    // FIFO pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and block ordering cannot matter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation tracking: count cycles the head waits; once the count has
    // reached the limit the pipeline is held for a slot, released after the
    // head drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
            r_pipe_stall <= 1'b0;
        end else begin
            if (w_empty || w_pop) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end

            if (w_pop) begin
                r_pipe_stall <= 1'b0;
            end else if (r_starve_cnt == STARVE_W'(STARVE_LIMIT)) begin
                r_pipe_stall <= 1'b1;
            end
        end
    end

    // Scoreboard: set wins over clear for the same register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
        end
    end

    // Write-port register; address/data hold when nothing is written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rw_en <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_rw_en <= w_wr_en;
            if (w_wr_en) begin
                r_waddr <= w_sel_rd;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign lu_ready_o   = !w_full;
    assign pipe_stall_o = r_pipe_stall;
    assign busy_o       = r_busy;
    assign dec_stall_o  = r_busy[rs1_addr_i] | r_busy[rs2_addr_i] | r_busy[rd_addr_i];
    assign rw_en_o      = r_rw_en;
    assign waddr_o      = r_waddr;
    assign wdata_o      = r_wdata;

    a_no_busy_reissue: assert property (@(posedge clk_i) disable iff (rst_i) !w_issue_conflict);

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the writeback arbiter.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            pipe_valid_i;
    logic [4:0]      pipe_rd_i;
    logic [XLEN-1:0] pipe_data_i;
    logic            pipe_stall_o;
    logic            lu_issue_i;
    logic [4:0]      lu_issue_rd_i;
    logic            lu_valid_i;
    logic [4:0]      lu_rd_i;
    logic [XLEN-1:0] lu_data_i;
    logic            lu_ready_o;
    logic [4:0]      rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic            dec_stall_o;
    logic [31:0]     busy_o;
    logic            rw_en_o;
    logic [4:0]      waddr_o;
    logic [XLEN-1:0] wdata_o;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.XLEN(XLEN), .LU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pipe_valid_i(pipe_valid_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .pipe_stall_o(pipe_stall_o),
        .lu_issue_i(lu_issue_i), .lu_issue_rd_i(lu_issue_rd_i),
        .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
        .lu_ready_o(lu_ready_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .dec_stall_o(dec_stall_o), .busy_o(busy_o),
        .rw_en_o(rw_en_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } res_t;

    res_t            m_q[$];          // buffered long-latency results, oldest first
    logic [4:0]      outstanding[$];  // issued destinations whose result is not yet buffered
    bit   [31:0]     m_busy;
    int              m_wait;          // consecutive cycles the head has waited
    bit              m_stall;
    bit              m_wen;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;

    int n_vec = 0;
    int n_err = 0;
    logic pre_dec_stall;
    logic pre_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        outstanding.delete();
        m_busy  = '0;
        m_wait  = 0;
        m_stall = 0;
        m_wen   = 0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    function automatic bit model_pops(input bit pv);
        return (m_q.size() != 0) && !(pv && !m_stall);
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, advance the
    // model, then check registered outputs just after the edge.
    task automatic step(input bit pv, input logic [4:0] prd, input logic [XLEN-1:0] pdata,
                        input bit iss, input logic [4:0] ird,
                        input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldata,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdd);
        bit   take, pop, push, sel;
        res_t sel_r;
        res_t nr;
        pipe_valid_i = pv;  pipe_rd_i = prd;     pipe_data_i = pdata;
        lu_issue_i   = iss; lu_issue_rd_i = ird;
        lu_valid_i   = lv;  lu_rd_i = lrd;       lu_data_i = ldata;
        rs1_addr_i   = rs1; rs2_addr_i = rs2;    rd_addr_i = rdd;
        #1;
        pre_dec_stall = dec_stall_o;
        pre_ready     = lu_ready_o;
        check("lu_ready", lu_ready_o, m_q.size() < DEPTH);
        check("dec_stall", dec_stall_o, m_busy[rs1] | m_busy[rs2] | m_busy[rdd]);

        take = pv && !m_stall;
        pop  = (m_q.size() != 0) && !take;
        push = lv && (m_q.size() < DEPTH);
        sel  = take || pop;
        if (take) begin
            sel_r.rd = prd; sel_r.data = pdata;
        end else if (pop) begin
            sel_r = m_q[0];
        end else begin
            sel_r.rd = '0; sel_r.data = '0;
        end
        m_wen = sel && (sel_r.rd != 0);
        if (m_wen) begin
            m_waddr = sel_r.rd;
            m_wdata = sel_r.data;
        end
        if (pop) m_busy[m_q[0].rd] = 1'b0;
        if (iss && ird != 0) begin
            m_busy[ird] = 1'b1;
            outstanding.push_back(ird);
        end
        m_busy[0] = 1'b0;
        m_stall = pop ? 1'b0 : (m_stall || m_wait >= LIMIT);
        m_wait  = (m_q.size() != 0 && !pop) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            nr.rd = lrd; nr.data = ldata;
            m_q.push_back(nr);
            if (lrd != 0) begin
                for (int i = 0; i < outstanding.size(); i++) begin
                    if (outstanding[i] == lrd) begin
                        outstanding.delete(i);
                        break;
                    end
                end
            end
        end

        @(posedge clk_i);
        #1;
        check("rw_en", rw_en_o, m_wen);
        check("waddr", waddr_o, m_waddr);
        check("wdata", wdata_o, m_wdata);
        check("pipe_stall", pipe_stall_o, m_stall);
        check("busy", busy_o, m_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit              saw_stall;
        logic [XLEN-1:0] pdat;
        bit              pv, lv, iss;
        logic [4:0]      prd, lrd, ird;
        logic [XLEN-1:0] ldat;

        rst_i = 1'b1;
        pipe_valid_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
        lu_issue_i = 0; lu_issue_rd_i = 0; lu_valid_i = 0; lu_rd_i = 0; lu_data_i = 0;
        rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("reset_rw_en", rw_en_o, 1'b0);
        check("reset_busy", busy_o, 32'd0);
        check("reset_ready", lu_ready_o, 1'b1);
        check("reset_stall", pipe_stall_o, 1'b0);

        // Pipeline-only writes.
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pipe_wen", rw_en_o, 1'b1);
        check("pipe_waddr", waddr_o, 5'd5);
        check("pipe_wdata", wdata_o, 32'hDEADBEEF);
        step(1, 5'd0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pipe_x0_wen", rw_en_o, 1'b0);

        // Long-latency path through the FIFO.
        step(0, 0, 0, 1, 5'd7, 0, 0, 0, 0, 0, 0);
        check("issue_busy7", busy_o[7], 1'b1);
        step(0, 0, 0, 0, 0, 1, 5'd7, 32'h12345678, 5'd7, 0, 0);
        check("raw_stall7", pre_dec_stall, 1'b1);
        check("lu_no_bypass", rw_en_o, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, 0);
        check("lu_wen", rw_en_o, 1'b1);
        check("lu_waddr", waddr_o, 5'd7);
        check("lu_wdata", wdata_o, 32'h12345678);
        check("clear_busy7", busy_o[7], 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, 0);
        check("raw_release7", pre_dec_stall, 1'b0);

        // FIFO full and starvation with the pipeline continuously valid.
        step(0, 0, 0, 1, 5'd10, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5'd11, 0, 0, 0, 0, 0, 0);
        step(1, 5'd12, 32'hA000_0000, 0, 0, 1, 5'd10, 32'h1010_1010, 0, 0, 0);
        step(1, 5'd13, 32'hA000_0001, 0, 0, 1, 5'd11, 32'h1111_1111, 0, 0, 0);
        check("full_not_ready", lu_ready_o, 1'b0);
        step(1, 5'd14, 32'hA000_0002, 0, 0, 1, 5'd0, 32'hBAD0_BAD0, 0, 0, 0);
        check("third_rejected", pre_ready, 1'b0);
        saw_stall = 0;
        prd = 5'd15; pdat = 32'hA000_0003;
        for (int i = 0; i < 16; i++) begin
            if (!m_stall) begin
                prd = 5'(15 + i); pdat = 32'hA000_0003 + i;
            end
            step(1, prd, pdat, 0, 0, 0, 0, 0, 0, 0, 0);
            if (pipe_stall_o) saw_stall = 1;
        end
        check("starve_stall_seen", saw_stall, 1'b1);
        idle(3);
        check("drained_ready", lu_ready_o, 1'b1);

        // Set/clear collision on the same destination.
        step(0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 5'd9, 32'h9999_0001, 0, 0, 0);
        step(0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0, 0);
        check("collision_busy9", busy_o[9], 1'b1);
        check("collision_waddr", waddr_o, 5'd9);
        step(0, 0, 0, 0, 0, 1, 5'd9, 32'h9999_0002, 0, 0, 0);
        idle(2);
        check("collision_cleared", busy_o[9], 1'b0);

        // Asynchronous reset with one result queued and a write on the port.
        step(0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0, 0);
        step(1, 5'd6, 32'h6666_6666, 0, 0, 1, 5'd3, 32'h3333_3333, 0, 0, 0);
        pipe_valid_i = 0; lu_valid_i = 0; lu_issue_i = 0;
        #2 rst_i = 1'b1;
        #1;
        check("arst_rw_en", rw_en_o, 1'b0);
        check("arst_waddr", waddr_o, 5'd0);
        check("arst_wdata", wdata_o, 32'd0);
        check("arst_stall", pipe_stall_o, 1'b0);
        check("arst_busy", busy_o, 32'd0);
        check("arst_ready", lu_ready_o, 1'b1);
        model_reset();
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        idle(3);
        check("post_arst_busy", busy_o, 32'd0);

        // Randomized traffic.
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (m_stall && pipe_valid_i) begin
                pv = 1; prd = pipe_rd_i; pdat = pipe_data_i;
            end else begin
                pv = ($urandom_range(0, 9) < 7); prd = 5'($urandom_range(0, 31)); pdat = $urandom;
            end
            lv = 0; lrd = 0; ldat = $urandom;
            if (outstanding.size() > 0 && $urandom_range(0, 9) < 4) begin
                lv = 1; lrd = outstanding[$urandom_range(0, outstanding.size() - 1)];
            end else if ($urandom_range(0, 19) == 0) begin
                lv = 1;
            end
            iss = 0; ird = 0;
            if ($urandom_range(0, 9) < 3) begin
                ird = 5'($urandom_range(1, 31));
                if (!m_busy[ird] || (model_pops(pv) && m_q[0].rd == ird)) iss = 1;
                else ird = 0;
            end
            step(pv, prd, pdat, iss, ird, lv, lrd, ldat,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Return every outstanding result and let the FIFO drain.
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (outstanding.size() > 0)
                step(0, 0, 0, 0, 0, 1, outstanding[0], $urandom, 0, 0, 0);
            else
                step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        check("final_busy", busy_o, 32'd0);
        check("final_ready", lu_ready_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
